sr_latch_ctrl: RTL and testbench
================================

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 2: cycles S or R is held high per command; legal range 1..15.
REQ-002 SHALL have parameter RECOV_CYC, default 1: idle cycles after a pulse before Q is checked; legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port set_req  input  1  level request to set the latch, held until ack.
REQ-006 SHALL have port clr_req  input  1  level request to reset the latch, held until ack.
REQ-007 SHALL have port ack  output  1  one-cycle completion pulse for the granted request.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port S  output  1  registered set drive to the latch.
REQ-010 SHALL have port R  output  1  registered reset drive to the latch.
REQ-011 SHALL have port Q  input  1  latch true output, fed back.
REQ-012 SHALL have port Q_not  input  1  latch complement output, fed back.
REQ-013 SHALL have port err  output  1  sticky fault flag.

Function
REQ-014 SHALL implement FSM states IDLE, PULSE, RECOVER, CHECK; IDLE->PULSE on any request, PULSE->RECOVER after PULSE_CYC cycles (->CHECK directly if RECOV_CYC=0), RECOVER->CHECK after RECOV_CYC cycles, CHECK->IDLE always.
REQ-015 SHALL never assert S and R in the same cycle, under any input or reset sequence.
REQ-016 SHALL, when a request is sampled in IDLE at edge n, drive S (set) or R (clear) high in cycles n+1..n+PULSE_CYC, both low otherwise.
REQ-017 SHALL assert ack for exactly the CHECK cycle, n+PULSE_CYC+RECOV_CYC+1; with defaults, ack occurs in cycle n+4.
REQ-018 SHALL arbitrate simultaneous set_req and clr_req round-robin via a last_grant bit, with set winning the first conflict after reset.
REQ-019 SHALL ignore requests outside IDLE without queuing them; a request still high on return to IDLE is served as a new command.
REQ-020 SHALL, in CHECK, set err if Q is not equal to the expected value (1 for set, 0 for clear) or if Q equals Q_not; ack is still issued.
REQ-021 SHALL hold err at 1 until rst.
REQ-022 SHALL issue the full pulse even when Q already equals the requested value.

Reset
REQ-023 SHALL, on an rst-high edge in any state including mid-pulse, force S=0, R=0, ack=0, busy=0, err=0, state=IDLE, counter=0, and last_grant=clear-side.
REQ-024 SHALL give rst priority over all requests in the same cycle.

Configuration
REQ-025 SHALL honour macro SR_LATCH_CTRL_CHECK_EN: when defined, REQ-020/021 apply; when undefined, err is tied 0, Q and Q_not are unused, and CHECK remains one cycle so that ack latency is unchanged.

Structure
REQ-026 SHALL take the state encoding, the default PULSE_CYC/RECOV_CYC constants, and the 4-bit counter width from shared package sr_latch_pkg.
REQ-027 SHALL use one sub-module, sr_pulse_timer (loadable 4-bit down-counter with a done flag), shared by the PULSE and RECOVER states.

Verification
REQ-028 SHALL verify: rst, then set_req=1 at cycle 0 with defaults -> S=1 in cycles 1-2, R=0 throughout, ack=1 in cycle 4 only, busy=1 in cycles 1-4, model latch Q=1, err=0.
REQ-029 SHALL verify: set_req and clr_req high together twice in succession -> first grant is set (S pulses), second is clear (R pulses), each with its own ack.
REQ-030 SHALL verify: clr_req with Q stuck at 1 by the bench -> ack in cycle 4, err=1 and staying 1 until rst (err stays 0 with SR_LATCH_CTRL_CHECK_EN undefined).
REQ-031 SHALL verify: rst asserted in cycle 2 of a set pulse -> S=0 the next cycle, busy=0, and no ack.
REQ-032 SHALL verify: PULSE_CYC=1, RECOV_CYC=0, with set_req held high -> S high for 1 cycle, ack 2 cycles after sampling, and a repeat command begins in the cycle after ack.
REQ-033 SHALL verify: randomized requests for 10k cycles -> assertion S&R is never 1, and every ack is preceded by exactly one pulse.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: shared state encoding, default timing constants and counter width for sr_latch_ctrl.
package sr_latch_pkg;
  localparam int CNT_W = 4;
  localparam int PULSE_CYC_DEF = 2;
  localparam int RECOV_CYC_DEF = 1;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_RECOVER, ST_CHECK} state_t;
  // Counter reload value for an N-cycle phase; a zero-length phase is never loaded.
  function automatic cnt_t phase_load(input int cyc);
    return cyc == 0 ? '0 : cnt_t'(cyc - 1);
  endfunction
endpackage

// File: rtl/sr_pulse_timer.sv
// sr_pulse_timer: loadable down-counter whose done flag marks the last cycle of a timed phase.
module sr_pulse_timer
  import sr_latch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  output logic done
);
  cnt_t cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: pulses S/R of an external SR latch per request, then checks Q (optional macro SR_LATCH_CTRL_CHECK_EN).
module sr_latch_ctrl
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int RECOV_CYC = RECOV_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic ack,
  output logic busy,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Q_not,
  output logic err
);
  localparam cnt_t P_LD = phase_load(PULSE_CYC);
  localparam cnt_t R_LD = phase_load(RECOV_CYC);
  localparam bit NO_RECOV = RECOV_CYC == 0;
  state_t state;
  logic last_set;
  logic req;
  logic grant_set;
  logic load;
  cnt_t load_val;
  logic done;
  assign req = set_req | clr_req;
  // On a conflict the side that did not win last time gets the grant.
  assign grant_set = set_req & (~clr_req | ~last_set);
  always_comb begin
    load = (state == ST_IDLE && req) || (state == ST_PULSE && done && !NO_RECOV);
    load_val = state == ST_IDLE ? P_LD : R_LD;
  end
  sr_pulse_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      S <= 1'b0;
      R <= 1'b0;
      ack <= 1'b0;
      busy <= 1'b0;
      last_set <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          state <= ST_PULSE;
          busy <= 1'b1;
          S <= grant_set;
          R <= ~grant_set;
          last_set <= grant_set;
        end
        ST_PULSE: if (done) begin
          S <= 1'b0;
          R <= 1'b0;
          state <= NO_RECOV ? ST_CHECK : ST_RECOVER;
          ack <= NO_RECOV;
        end
        ST_RECOVER: if (done) begin
          state <= ST_CHECK;
          ack <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
`ifdef SR_LATCH_CTRL_CHECK_EN
  // last_set still names the side being served while in CHECK.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (state == ST_CHECK && (Q != last_set || Q == Q_not)) err <= 1'b1;
  end
`else
  logic unused_fb;
  assign unused_fb = Q ^ Q_not;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed and randomized checks of sr_latch_ctrl against a schedule-based reference model.
module tb_sr_latch_ctrl;
  localparam int P = 2;
  localparam int RC = 1;
  localparam int NR = 10000;
`ifdef SR_LATCH_CTRL_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set0 = 1'b0, clr0 = 1'b0, set1 = 1'b0, clr1 = 1'b0;
  logic ack0, busy0, s0, r0, err0, ack1, busy1, s1, r1, err1;
  logic lq = 1'b0;
  logic stuck = 1'b0;
  logic q0, qn0;
  int checks = 0;
  int errors = 0;
  bit es[NR+8], er[NR+8], ea[NR+8], eb[NR+8];
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (s0) lq <= 1'b1;
    else if (r0) lq <= 1'b0;
  end
  assign q0 = stuck ? 1'b1 : lq;
  assign qn0 = stuck ? 1'b0 : ~lq;
  sr_latch_ctrl u0 (
    .clk(clk), .rst(rst), .set_req(set0), .clr_req(clr0), .ack(ack0), .busy(busy0),
    .S(s0), .R(r0), .Q(q0), .Q_not(qn0), .err(err0)
  );
  sr_latch_ctrl #(.PULSE_CYC(1), .RECOV_CYC(0)) u1 (
    .clk(clk), .rst(rst), .set_req(set1), .clr_req(clr1), .ack(ack1), .busy(busy1),
    .S(s1), .R(r1), .Q(1'b1), .Q_not(1'b0), .err(err1)
  );
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    set0 = 1'b0;
    clr0 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask
  // Walks one command on u0 from its sampling cycle up to and including its ack cycle.
  task automatic run_cmd(input string tag, input bit exp_set);
    for (int k = 1; k <= P + RC + 1; k++) begin
      step();
      chk({tag, "_S"}, s0, exp_set && k <= P);
      chk({tag, "_R"}, r0, !exp_set && k <= P);
      chk({tag, "_ack"}, ack0, k == P + RC + 1);
      chk({tag, "_busy"}, busy0, 1'b1);
      chk({tag, "_err"}, err0, 1'b0);
    end
  endtask
  initial begin
    int free_at, pulses;
    bit lg_set, prev_pulse, rs, rr, g;
    do_reset();
    chk("rst_S", s0, 1'b0);
    chk("rst_R", r0, 1'b0);
    chk("rst_ack", ack0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_err", err0, 1'b0);
    set0 = 1'b1;
    run_cmd("set", 1'b1);
    set0 = 1'b0;
    step();
    chk("set_idle_busy", busy0, 1'b0);
    chk("set_idle_ack", ack0, 1'b0);
    chk("set_latch_q", lq, 1'b1);
    chk("set_err", err0, 1'b0);
    do_reset();
    set0 = 1'b1;
    clr0 = 1'b1;
    run_cmd("rr_first", 1'b1);
    step();
    chk("rr_gap_busy", busy0, 1'b0);
    chk("rr_gap_S", s0, 1'b0);
    run_cmd("rr_second", 1'b0);
    set0 = 1'b0;
    clr0 = 1'b0;
    step();
    chk("rr_latch_q", lq, 1'b0);
    do_reset();
    stuck = 1'b1;
    clr0 = 1'b1;
    run_cmd("stuck", 1'b0);
    clr0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stuck_err", err0, EXP_ERR);
    end
    stuck = 1'b0;
    do_reset();
    chk("stuck_err_rst", err0, 1'b0);
    set0 = 1'b1;
    step();
    chk("abort_S1", s0, 1'b1);
    step();
    chk("abort_S2", s0, 1'b1);
    rst = 1'b1;
    set0 = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_S", s0, 1'b0);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_ack", ack0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("abort_no_ack", ack0, 1'b0);
      chk("abort_no_S", s0, 1'b0);
    end
    set1 = 1'b1;
    step();
    chk("fast_S1", s1, 1'b1);
    chk("fast_ack1", ack1, 1'b0);
    step();
    chk("fast_S2", s1, 1'b0);
    chk("fast_ack2", ack1, 1'b1);
    step();
    chk("fast_idle_busy", busy1, 1'b0);
    chk("fast_idle_ack", ack1, 1'b0);
    step();
    chk("fast_repeat_S", s1, 1'b1);
    chk("fast_repeat_R", r1, 1'b0);
    set1 = 1'b0;
    do_reset();
    for (int c = 0; c < NR + 8; c++) begin
      es[c] = 1'b0;
      er[c] = 1'b0;
      ea[c] = 1'b0;
      eb[c] = 1'b0;
    end
    free_at = 0;
    lg_set = 1'b0;
    pulses = 0;
    prev_pulse = 1'b0;
    for (int c = 0; c < NR; c++) begin
      chk("rnd_S", s0, es[c]);
      chk("rnd_R", r0, er[c]);
      chk("rnd_ack", ack0, ea[c]);
      chk("rnd_busy", busy0, eb[c]);
      chk("rnd_s_and_r", s0 & r0, 1'b0);
      chk("rnd_err", err0, 1'b0);
      if ((s0 | r0) && !prev_pulse) pulses++;
      prev_pulse = s0 | r0;
      if (ack0) begin
        chk("rnd_one_pulse_per_ack", pulses == 1, 1'b1);
        pulses = 0;
      end
      rs = $urandom_range(0, 2) == 0;
      rr = $urandom_range(0, 2) == 0;
      set0 = rs;
      clr0 = rr;
      if (c >= free_at && (rs || rr)) begin
        g = rs && rr ? !lg_set : rs;
        lg_set = g;
        for (int k = 1; k <= P + RC + 1; k++) begin
          es[c+k] = g && k <= P;
          er[c+k] = !g && k <= P;
          eb[c+k] = 1'b1;
        end
        ea[c+P+RC+1] = 1'b1;
        free_at = c + P + RC + 2;
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
